// File: rtl/fb_port_ctrl.sv
// Frame buffer port responder: turns the capture controller's active-low write/read
// requests into Avalon-MM bursts and reports full / rd_done / read data back.
module fb_port_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 25,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 307200,
    parameter int BURST_LEN   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              swap,
    output logic              avl_ready,
    output logic              full,
    output logic              rd_done,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_req,
    output logic              mem_read_req,
    output logic              mem_burstbegin,
    output logic [6:0]        mem_size,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int BW = 7;
    localparam logic [CW-1:0] FW    = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] BL    = CW'(BURST_LEN);
    localparam logic [BW-1:0] BL_M1 = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_CMD, S_RD_WAIT} state_t;

    state_t          state;
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;
    logic [CW-1:0]   rd_ret;
    logic [BW-1:0]   beat;
    logic [BW-1:0]   rd_cnt;
    logic            swap_pend;
    logic            wr_phase;
    logic            swap_now;
    logic            wr_acc;
    logic            rd_beat;

    // A pending swap owns the idle cycle, so no beat is accepted against stale pointers.
    assign wr_phase       = (state == S_IDLE) || (state == S_WR);
    assign swap_now       = (state == S_IDLE) && (swap || swap_pend);
    assign mem_write_req  = reset && !wr_en && !full && wr_phase && !swap_now;
    assign avl_ready      = mem_ready && !full && wr_phase && !swap_now;
    assign wr_acc         = mem_write_req && mem_ready;
    assign mem_wdata      = wr_data;
    assign mem_read_req   = (state == S_RD_CMD);
    assign mem_burstbegin = mem_read_req || (mem_write_req && (beat == '0));
    assign mem_size       = 7'(BURST_LEN);
    assign rd_beat        = mem_rdata_valid && (state == S_RD_WAIT);

    always_comb begin
        mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_ptr - CW'(beat));
        if (state == S_RD_CMD)
            mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_ptr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rd_ret        <= '0;
            beat          <= '0;
            rd_cnt        <= '0;
            swap_pend     <= 1'b0;
            full          <= 1'b0;
            rd_done       <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_data_valid <= rd_beat;
            if (rd_beat)
                rd_data <= mem_rdata;
            if (swap && (state != S_IDLE))
                swap_pend <= 1'b1;

            // Write beats share one step for both S_IDLE and S_WR.
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == FW) ? FW : wr_ptr + CW'(1);
                if (wr_ptr == FW - CW'(1))
                    full <= 1'b1;
                if (beat == BL_M1) begin
                    beat  <= '0;
                    state <= S_IDLE;
                end else begin
                    beat  <= beat + BW'(1);
                    state <= S_WR;
                end
            end

            case (state)
                S_IDLE: begin
                    if (swap_now) begin
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        rd_ret    <= '0;
                        beat      <= '0;
                        full      <= 1'b0;
                        rd_done   <= 1'b0;
                        swap_pend <= 1'b0;
                    end else if (!wr_acc && !rd_en && !rd_done) begin
                        state <= S_RD_CMD;
                    end
                end
                S_WR: ;
                S_RD_CMD: begin
                    if (mem_ready) begin
                        rd_ptr <= (rd_ptr >= FW - BL) ? FW : rd_ptr + BL;
                        rd_cnt <= '0;
                        state  <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rdata_valid) begin
                        rd_ret <= (rd_ret == FW) ? FW : rd_ret + CW'(1);
                        if (rd_ret == FW - CW'(1))
                            rd_done <= 1'b1;
                        if (rd_cnt == BL_M1) begin
                            rd_cnt <= '0;
                            state  <= S_IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + BW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_port_ctrl.sv
// Directed bench for fb_port_ctrl: 32-word frame, 8-word bursts, base address 0x100.
module tb_fb_port_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 25;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              swap;
    logic              avl_ready;
    logic              full;
    logic              rd_done;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write_req;
    logic              mem_read_req;
    logic              mem_burstbegin;
    logic [6:0]        mem_size;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rdata_valid;
    logic [DATA_W-1:0] mem_rdata;

    int chk_cnt = 0;
    int err_cnt = 0;

    fb_port_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(32'h100),
        .FRAME_WORDS(32), .BURST_LEN(8)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .swap(swap), .avl_ready(avl_ready), .full(full), .rd_done(rd_done),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .mem_addr(mem_addr),
        .mem_write_req(mem_write_req), .mem_read_req(mem_read_req),
        .mem_burstbegin(mem_burstbegin), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one 8-beat write burst; mem_ready follows rdy_pat, one bit per cycle.
    task automatic write_burst(input logic [ADDR_W-1:0] start, input logic [31:0] dbase,
                               input logic [15:0] rdy_pat);
        int n;
        int cyc;
        n   = 0;
        cyc = 0;
        wr_en = 1'b0;
        while (n < 8 && cyc < 64) begin
            mem_ready = rdy_pat[cyc % 16];
            wr_data   = dbase + 32'(n);
            #1;
            check("wr_req", mem_write_req, 1);
            check("avl_ready", avl_ready, mem_ready);
            check("wr_addr", mem_addr, start);
            check("wr_bb", mem_burstbegin, n == 0);
            check("wr_data", mem_wdata, dbase + 32'(n));
            if (!rd_en)
                check("rd_req_in_wr", mem_read_req, 0);
            if (mem_ready)
                n++;
            tick();
            cyc++;
        end
        wr_en     = 1'b1;
        mem_ready = 1'b1;
        if (n < 8)
            check("wr_timeout", n, 8);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b1; rd_en = 1'b1; swap = 1'b0; wr_data = '0;
        mem_ready = 1'b1; mem_rdata_valid = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        check("rst_full", full, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_rdv", rd_data_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_req", mem_write_req, 0);
        check("rst_rd_req", mem_read_req, 0);
        check("rst_bb", mem_burstbegin, 0);
        check("mem_size", mem_size, 8);
        reset = 1'b1;
        tick();

        // Fill the frame: one clean burst, one with mem_ready toggling, two more.
        write_burst(25'h100, 32'hA000, 16'hFFFF);
        write_burst(25'h108, 32'hA008, 16'b0101_1010_0110_0101);
        write_burst(25'h110, 32'hA010, 16'hFFFF);
        check("full_early", full, 0);
        write_burst(25'h118, 32'hA018, 16'hFFFF);
        check("full_set", full, 1);
        wr_en = 1'b0;
        #1;
        check("full_wr_req", mem_write_req, 0);
        check("full_avl_ready", avl_ready, 0);
        tick();
        check("full_hold", full, 1);
        check("full_wr_req2", mem_write_req, 0);
        wr_en = 1'b1;

        // Read the whole frame back with rd_en held low.
        rd_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b0;
            tick();
            check("rd_cmd", mem_read_req, 1);
            check("rd_cmd_bb", mem_burstbegin, 1);
            check("rd_cmd_addr", mem_addr, 32'h100 + 32'(8 * k));
            tick();
            check("rd_cmd_hold", mem_read_req, 1);
            check("rd_cmd_addr_hold", mem_addr, 32'h100 + 32'(8 * k));
            mem_ready = 1'b1;
            tick();
            check("rd_cmd_drop", mem_read_req, 0);
            for (int j = 0; j < 8; j++) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = 32'hD000 + 32'(8 * k + j);
                if (j == 0) begin
                    #1;
                    check("rdv_lag", rd_data_valid, 0);
                end
                tick();
                check("rdv", rd_data_valid, 1);
                check("rd_data", rd_data, 32'hD000 + 32'(8 * k + j));
                check("rd_done", rd_done, (k == 3) && (j == 7));
                check("rd_req_wait", mem_read_req, 0);
            end
            mem_rdata_valid = 1'b0;
        end
        tick();
        check("rdv_end", rd_data_valid, 0);
        check("rd_done_hold", rd_done, 1);
        check("no_5th_cmd", mem_read_req, 0);
        tick();
        check("no_5th_cmd2", mem_read_req, 0);

        // Swap rewinds everything.
        rd_en = 1'b1;
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check("swap_full", full, 0);
        check("swap_rd_done", rd_done, 0);

        // Write wins over read in idle; the read follows once wr_en releases.
        rd_en = 1'b0;
        write_burst(25'h100, 32'hB000, 16'hFFFF);
        mem_ready = 1'b0;
        tick();
        check("prio_rd_cmd", mem_read_req, 1);
        check("prio_rd_addr", mem_addr, 25'h100);
        wr_en = 1'b0;
        #1;
        check("stall_avl_cmd", avl_ready, 0);
        check("stall_wr_cmd", mem_write_req, 0);
        mem_ready = 1'b1;
        tick();
        check("stall_avl_wait", avl_ready, 0);
        check("stall_wr_wait", mem_write_req, 0);
        for (int j = 0; j < 3; j++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = 32'hE000 + 32'(j);
            tick();
            check("part_rdv", rd_data_valid, 1);
            check("part_avl", avl_ready, 0);
        end

        // Reset in the middle of a read burst, then stale beats.
        reset = 1'b0; mem_rdata_valid = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        check("mrst_rdv", rd_data_valid, 0);
        check("mrst_rd_data", rd_data, 0);
        check("mrst_rd_req", mem_read_req, 0);
        check("mrst_wr_req", mem_write_req, 0);
        check("mrst_bb", mem_burstbegin, 0);
        check("mrst_full", full, 0);
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = 32'hF000 + 32'(j);
            tick();
            check("stale_rdv", rd_data_valid, 0);
            check("stale_rd_req", mem_read_req, 0);
        end
        mem_rdata_valid = 1'b0;
        wr_en = 1'b0;
        #1;
        check("mrst_wr_addr", mem_addr, 25'h100);
        check("mrst_wr_bb", mem_burstbegin, 1);
        wr_en = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
